// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM controller command path.
// State encoding, pin command codes and default bus widths.
package sdram_pkg;

   localparam int unsigned CMD_W  = 4;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned BA_W   = 2;
   localparam int unsigned DQ_W   = 16;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP         = 4'b0111;
   localparam logic [3:0] CMD_PRECHARGE   = 4'b0010;
   localparam logic [3:0] CMD_AUTOREFRESH = 4'b0001;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_AREF,
      ST_WRITE,
      ST_READ
   } arb_state_t;

endpackage

// File: rtl/sdram_cmd_reg.sv
// Registered SDRAM pin stage: command, bank, address, write data and drive enable.
// Reset forces the command pins high (deselect) and clears everything else.
module sdram_cmd_reg #(
   parameter int unsigned CMD_W  = 4,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned BA_W   = 2,
   parameter int unsigned DQ_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CMD_W-1:0]  cmd_d,
   input  logic [BA_W-1:0]   ba_d,
   input  logic [ADDR_W-1:0] addr_d,
   input  logic [DQ_W-1:0]   dq_d,
   input  logic              oe_d,
   output logic [CMD_W-1:0]  cmd_q,
   output logic [BA_W-1:0]   ba_q,
   output logic [ADDR_W-1:0] addr_q,
   output logic [DQ_W-1:0]   dq_q,
   output logic              oe_q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_q  <= '1;
         ba_q   <= '0;
         addr_q <= '0;
         dq_q   <= '0;
         oe_q   <= 1'b0;
      end else begin
         cmd_q  <= cmd_d;
         ba_q   <= ba_d;
         addr_q <= addr_d;
         dq_q   <= dq_d;
         oe_q   <= oe_d;
      end
   end

endmodule

// File: rtl/sdram_arbit.sv
// Central SDRAM command arbiter: init first, then fixed priority refresh > write > read,
// holding each grant until the owner's end flag and registering the selected bus to the pins.
module sdram_arbit #(
   parameter int unsigned CMD_W  = sdram_pkg::CMD_W,
   parameter int unsigned ADDR_W = sdram_pkg::ADDR_W,
   parameter int unsigned BA_W   = sdram_pkg::BA_W,
   parameter int unsigned DQ_W   = sdram_pkg::DQ_W
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [CMD_W-1:0]  init_cmd,
   input  logic [BA_W-1:0]   init_ba,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              init_end_flag,
   input  logic              ref_req,
   output logic              ref_en,
   input  logic              ref_end_flag,
   input  logic [CMD_W-1:0]  ref_cmd,
   input  logic [ADDR_W-1:0] ref_addr,
   input  logic              wr_req,
   output logic              wr_en,
   input  logic              wr_end_flag,
   input  logic [CMD_W-1:0]  wr_cmd,
   input  logic [BA_W-1:0]   wr_ba,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DQ_W-1:0]   wr_dq,
   input  logic              wr_dq_oe,
   input  logic              rd_req,
   output logic              rd_en,
   input  logic              rd_end_flag,
   input  logic [CMD_W-1:0]  rd_cmd,
   input  logic [BA_W-1:0]   rd_ba,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [BA_W-1:0]   sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [DQ_W-1:0]   sdram_dq_out,
   output logic              sdram_dq_oe
);

   import sdram_pkg::*;

   arb_state_t        state_q, state_d;
   logic [CMD_W-1:0]  cmd_d;
   logic [BA_W-1:0]   ba_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DQ_W-1:0]   dq_d;
   logic              oe_d;
   logic [CMD_W-1:0]  pin_cmd;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= ST_INIT;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT: if (init_end_flag) state_d = ST_IDLE;
         ST_IDLE: begin
            if      (ref_req) state_d = ST_AREF;
            else if (wr_req)  state_d = ST_WRITE;
            else if (rd_req)  state_d = ST_READ;
         end
         ST_AREF:  if (ref_end_flag) state_d = ST_IDLE;
         ST_WRITE: if (wr_end_flag)  state_d = ST_IDLE;
         ST_READ:  if (rd_end_flag)  state_d = ST_IDLE;
         default:  state_d = ST_INIT;
      endcase
      // Loss of init completion outranks any end flag and aborts the current owner.
      if (state_q != ST_INIT && !init_end_flag) state_d = ST_INIT;
   end

   always_comb begin
      cmd_d  = CMD_W'(CMD_NOP);
      ba_d   = '0;
      addr_d = '0;
      dq_d   = '0;
      oe_d   = 1'b0;
      unique case (state_q)
         ST_INIT: begin
            cmd_d  = init_cmd;
            ba_d   = init_ba;
            addr_d = init_addr;
         end
         ST_AREF: begin
            cmd_d  = ref_cmd;
            addr_d = ref_addr;
         end
         ST_WRITE: begin
            cmd_d  = wr_cmd;
            ba_d   = wr_ba;
            addr_d = wr_addr;
            dq_d   = wr_dq;
            oe_d   = wr_dq_oe;
         end
         ST_READ: begin
            cmd_d  = rd_cmd;
            ba_d   = rd_ba;
            addr_d = rd_addr;
         end
         default: ;
      endcase
   end

   assign ref_en = (state_q == ST_AREF);
   assign wr_en  = (state_q == ST_WRITE);
   assign rd_en  = (state_q == ST_READ);

   sdram_cmd_reg #(
      .CMD_W  (CMD_W),
      .ADDR_W (ADDR_W),
      .BA_W   (BA_W),
      .DQ_W   (DQ_W)
   ) u_cmd_reg (
      .clk    (sys_clk),
      .rst    (sys_rst),
      .cmd_d  (cmd_d),
      .ba_d   (ba_d),
      .addr_d (addr_d),
      .dq_d   (dq_d),
      .oe_d   (oe_d),
      .cmd_q  (pin_cmd),
      .ba_q   (sdram_ba),
      .addr_q (sdram_addr),
      .dq_q   (sdram_dq_out),
      .oe_q   (sdram_dq_oe)
   );

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed self-checking bench for sdram_arbit: init, priority, data path, stray flags,
// asynchronous reset mid-write and re-initialisation.
module tb_sdram_arbit;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [3:0]  init_cmd;
   logic [1:0]  init_ba;
   logic [11:0] init_addr;
   logic        init_end_flag;
   logic        ref_req, ref_en, ref_end_flag;
   logic [3:0]  ref_cmd;
   logic [11:0] ref_addr;
   logic        wr_req, wr_en, wr_end_flag;
   logic [3:0]  wr_cmd;
   logic [1:0]  wr_ba;
   logic [11:0] wr_addr;
   logic [15:0] wr_dq;
   logic        wr_dq_oe;
   logic        rd_req, rd_en, rd_end_flag;
   logic [3:0]  rd_cmd;
   logic [1:0]  rd_ba;
   logic [11:0] rd_addr;
   logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_ba;
   logic [11:0] sdram_addr;
   logic [15:0] sdram_dq_out;
   logic        sdram_dq_oe;
   logic [3:0]  pins;
   logic [2:0]  grants;

   int errors = 0;
   int checks = 0;

   assign pins   = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
   assign grants = {ref_en, wr_en, rd_en};

   always #5 sys_clk = ~sys_clk;

   sdram_arbit #(.CMD_W(4), .ADDR_W(12), .BA_W(2), .DQ_W(16)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr), .init_end_flag(init_end_flag),
      .ref_req(ref_req), .ref_en(ref_en), .ref_end_flag(ref_end_flag), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
      .wr_req(wr_req), .wr_en(wr_en), .wr_end_flag(wr_end_flag), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
      .wr_addr(wr_addr), .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe),
      .rd_req(rd_req), .rd_en(rd_en), .rd_end_flag(rd_end_flag), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
      .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
      .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
   );

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      init_cmd = 4'b0111; init_ba = 2'd0; init_addr = 12'h000; init_end_flag = 1'b0;
      ref_req = 0; ref_end_flag = 0; ref_cmd = 4'b0111; ref_addr = 12'h000;
      wr_req = 0; wr_end_flag = 0; wr_cmd = 4'b0111; wr_ba = 0; wr_addr = 0; wr_dq = 0; wr_dq_oe = 0;
      rd_req = 0; rd_end_flag = 0; rd_cmd = 4'b0111; rd_ba = 0; rd_addr = 0;
      #3;
      checks++; if (pins !== 4'b1111) begin errors++; $display("FAIL reset_pins got=%b exp=1111", pins); end
      checks++; if (grants !== 3'b000) begin errors++; $display("FAIL reset_grants got=%b exp=000", grants); end
      checks++; if ({sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe} !== 31'd0) begin
         errors++; $display("FAIL reset_bus got ba=%h addr=%h dq=%h oe=%b exp=0", sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe);
      end
      tick();
      checks++; if (pins !== 4'b1111) begin errors++; $display("FAIL reset_hold_pins got=%b exp=1111", pins); end
      sys_rst = 1'b0;
   endtask

   task automatic test_init();
      init_cmd = 4'b0010; init_addr = 12'h400; init_ba = 2'd0;
      wr_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (pins !== 4'b0010 || sdram_addr !== 12'h400) begin
            errors++; $display("FAIL init_fwd[%0d] got cmd=%b addr=%h exp cmd=0010 addr=400", i, pins, sdram_addr);
         end
         checks++; if (grants !== 3'b000) begin errors++; $display("FAIL init_ignore_req[%0d] got=%b exp=000", i, grants); end
      end
      wr_req = 1'b0;
      init_end_flag = 1'b1;
      tick();
      checks++; if (pins !== 4'b0010) begin errors++; $display("FAIL init_last_cmd got=%b exp=0010", pins); end
      tick();
      checks++; if (pins !== 4'b0111 || sdram_addr !== 12'h000) begin
         errors++; $display("FAIL idle_nop got cmd=%b addr=%h exp cmd=0111 addr=000", pins, sdram_addr);
      end
      checks++; if (grants !== 3'b000) begin errors++; $display("FAIL idle_grants got=%b exp=000", grants); end
   endtask

   task automatic test_priority();
      ref_req = 1'b1; wr_req = 1'b1;
      tick();
      checks++; if (grants !== 3'b100) begin errors++; $display("FAIL prio_ref_first got=%b exp=100", grants); end
      ref_req = 1'b0; ref_cmd = 4'b0001; ref_addr = 12'h0AA;
      tick();
      checks++; if (pins !== 4'b0001 || sdram_addr !== 12'h0AA || sdram_ba !== 2'd0) begin
         errors++; $display("FAIL aref_bus got cmd=%b ba=%h addr=%h exp cmd=0001 ba=0 addr=0aa", pins, sdram_ba, sdram_addr);
      end
      checks++; if (grants !== 3'b100) begin errors++; $display("FAIL aref_hold got=%b exp=100", grants); end
      ref_end_flag = 1'b1;
      tick();
      ref_end_flag = 1'b0;
      checks++; if (grants !== 3'b000) begin errors++; $display("FAIL aref_release got=%b exp=000", grants); end
      tick();
      checks++; if (grants !== 3'b010) begin errors++; $display("FAIL wr_after_gap got=%b exp=010", grants); end
      checks++; if (pins !== 4'b0111) begin errors++; $display("FAIL gap_nop got=%b exp=0111", pins); end
   endtask

   task automatic test_data_path();
      wr_req = 1'b0; wr_cmd = 4'b0100; wr_ba = 2'd2; wr_addr = 12'h123; wr_dq = 16'hA5A5; wr_dq_oe = 1'b1;
      tick();
      checks++; if (pins !== 4'b0100 || sdram_ba !== 2'd2 || sdram_addr !== 12'h123) begin
         errors++; $display("FAIL wr_bus got cmd=%b ba=%h addr=%h exp cmd=0100 ba=2 addr=123", pins, sdram_ba, sdram_addr);
      end
      checks++; if (sdram_dq_out !== 16'hA5A5 || sdram_dq_oe !== 1'b1) begin
         errors++; $display("FAIL wr_data got dq=%h oe=%b exp dq=a5a5 oe=1", sdram_dq_out, sdram_dq_oe);
      end
      wr_end_flag = 1'b1;
      tick();
      wr_end_flag = 1'b0;
      checks++; if (grants !== 3'b000) begin errors++; $display("FAIL wr_release got=%b exp=000", grants); end
      tick();
      checks++; if (sdram_dq_oe !== 1'b0 || sdram_dq_out !== 16'h0000) begin
         errors++; $display("FAIL idle_dq got dq=%h oe=%b exp dq=0000 oe=0", sdram_dq_out, sdram_dq_oe);
      end
      rd_req = 1'b1;
      tick();
      checks++; if (grants !== 3'b001) begin errors++; $display("FAIL rd_grant got=%b exp=001", grants); end
      rd_req = 1'b0; rd_cmd = 4'b0101; rd_ba = 2'd1; rd_addr = 12'h2F0;
      tick();
      checks++; if (pins !== 4'b0101 || sdram_ba !== 2'd1 || sdram_addr !== 12'h2F0) begin
         errors++; $display("FAIL rd_bus got cmd=%b ba=%h addr=%h exp cmd=0101 ba=1 addr=2f0", pins, sdram_ba, sdram_addr);
      end
      checks++; if (sdram_dq_oe !== 1'b0 || sdram_dq_out !== 16'h0000) begin
         errors++; $display("FAIL rd_no_drive got dq=%h oe=%b exp dq=0000 oe=0", sdram_dq_out, sdram_dq_oe);
      end
   endtask

   task automatic test_ref_during_read();
      ref_req = 1'b1; wr_req = 1'b1;
      tick();
      checks++; if (grants !== 3'b001) begin errors++; $display("FAIL rd_not_preempted got=%b exp=001", grants); end
      rd_end_flag = 1'b1;
      tick();
      rd_end_flag = 1'b0;
      checks++; if (grants !== 3'b000) begin errors++; $display("FAIL rd_release got=%b exp=000", grants); end
      tick();
      checks++; if (grants !== 3'b100) begin errors++; $display("FAIL ref_before_wr got=%b exp=100", grants); end
   endtask

   task automatic test_stray_end();
      ref_req = 1'b0; wr_end_flag = 1'b1; rd_end_flag = 1'b1;
      tick();
      wr_end_flag = 1'b0; rd_end_flag = 1'b0;
      checks++; if (grants !== 3'b100) begin errors++; $display("FAIL stray_end got=%b exp=100", grants); end
      tick();
      checks++; if (grants !== 3'b100) begin errors++; $display("FAIL stray_hold got=%b exp=100", grants); end
      ref_end_flag = 1'b1;
      tick();
      ref_end_flag = 1'b0;
      checks++; if (grants !== 3'b000) begin errors++; $display("FAIL stray_release got=%b exp=000", grants); end
      tick();
      checks++; if (grants !== 3'b010) begin errors++; $display("FAIL wr_after_ref got=%b exp=010", grants); end
   endtask

   task automatic test_reset_mid_write();
      wr_req = 1'b0; wr_dq_oe = 1'b1;
      tick();
      checks++; if (sdram_dq_oe !== 1'b1 || pins !== 4'b0100) begin
         errors++; $display("FAIL pre_rst_wr got cmd=%b oe=%b exp cmd=0100 oe=1", pins, sdram_dq_oe);
      end
      #3 sys_rst = 1'b1;
      #1;
      checks++; if (grants !== 3'b000) begin errors++; $display("FAIL rst_mid_grants got=%b exp=000", grants); end
      checks++; if (pins !== 4'b1111 || sdram_dq_oe !== 1'b0 || sdram_dq_out !== 16'h0 || sdram_addr !== 12'h0) begin
         errors++; $display("FAIL rst_mid_pins got cmd=%b oe=%b dq=%h addr=%h exp cmd=1111 oe=0 dq=0 addr=0",
                            pins, sdram_dq_oe, sdram_dq_out, sdram_addr);
      end
      init_end_flag = 1'b0; wr_req = 1'b1;
      tick();
      sys_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (grants !== 3'b000 || pins !== 4'b0010) begin
            errors++; $display("FAIL post_rst_init[%0d] got grants=%b cmd=%b exp grants=000 cmd=0010", i, grants, pins);
         end
      end
      init_end_flag = 1'b1;
      tick();
      tick();
      checks++; if (grants !== 3'b010) begin errors++; $display("FAIL post_rst_wr got=%b exp=010", grants); end
   endtask

   task automatic test_reinit();
      init_end_flag = 1'b0;
      tick();
      checks++; if (grants !== 3'b000) begin errors++; $display("FAIL reinit_grants got=%b exp=000", grants); end
      tick();
      checks++; if (pins !== 4'b0010 || sdram_addr !== 12'h400) begin
         errors++; $display("FAIL reinit_fwd got cmd=%b addr=%h exp cmd=0010 addr=400", pins, sdram_addr);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_priority();
      test_data_path();
      test_ref_during_read();
      test_stray_end();
      test_reset_mid_write();
      test_reinit();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Central command arbiter for the SDRAM controller. It sits between the initialisation, auto-refresh, write and read sub-modules and the SDRAM pins, and owns the single command/address/data bus. It sequences power-up (init first), then grants the bus to one requester at a time using fixed priority refresh > write > read. It holds each grant until that requester signals completion, then registers the selected command onto the pins.

## Interface
- CMD_W, 4, command width, ordered {cs_n, ras_n, cas_n, we_n}
- ADDR_W, 12, SDRAM row/column address width
- BA_W, 2, bank address width
- DQ_W, 16, data bus width
- sys_clk  in  1  single clock for the whole block
- sys_rst  in  1  asynchronous, active-high reset
- init_cmd / init_ba / init_addr  in  CMD_W / BA_W / ADDR_W  init sub-module bus
- init_end_flag  in  1  level; high once power-up sequence is complete
- ref_req  in  1  refresh request (level, held until served)
- ref_en  out  1  refresh grant
- ref_end_flag  in  1  one-cycle pulse, refresh finished
- ref_cmd / ref_addr  in  CMD_W / ADDR_W  refresh bus (bank forced 0)
- wr_req, rd_req  in  1  write/read requests (level)
- wr_en, rd_en  out  1  write/read grants
- wr_end_flag, rd_end_flag  in  1  one-cycle completion pulses
- wr_cmd / wr_ba / wr_addr, rd_cmd / rd_ba / rd_addr  in  CMD_W / BA_W / ADDR_W  write/read buses
- wr_dq  in  DQ_W  write data; wr_dq_oe  in  1  write data drive enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1  registered pin command
- sdram_ba  out  BA_W; sdram_addr  out  ADDR_W  registered pin address
- sdram_dq_out  out  DQ_W; sdram_dq_oe  out  1  registered tristate data/enable

## Operation
- States: INIT, IDLE, AREF, WRITE, READ.
- INIT: forward init bus. Go to IDLE on the first cycle with init_end_flag=1. Requests are ignored in INIT.
- IDLE: pin command NOP (4'b0111), ba/addr 0.
- Arbitration in IDLE, evaluated every cycle:
  - ref_req → AREF
  - else wr_req → WRITE
  - else rd_req → READ
  - else stay in IDLE.
- AREF/WRITE/READ: the matching grant (ref_en/wr_en/rd_en) is high for the whole state. It is a combinational decode of the state register and stays high up to and including the end-flag cycle. The matching bus is forwarded.
- On the matching end flag, go to IDLE. End flags from non-granted requesters are ignored.
- Grants are one-hot. A grant never drops before its end flag, because sub-modules abort when their enable drops.
- sdram_dq_oe = wr_dq_oe only in WRITE; otherwise 0. sdram_dq_out = wr_dq in WRITE, otherwise 0.
- If init_end_flag falls while in any state other than INIT, go to INIT (re-initialisation).

## Timing
- Reset (asynchronous, sys_rst=1):
  - state=INIT
  - all grants 0
  - sdram_{cs_n,ras_n,cas_n,we_n}=1,1,1,1
  - sdram_ba=0, sdram_addr=0, sdram_dq_out=0, sdram_dq_oe=0.
- Pin outputs are registered. The sub-module bus at cycle N appears on the pins at N+1, with data and oe aligned to the command.
- Grant latency: request seen in IDLE at cycle N → state and grant at N+1.
- Release: end flag at cycle M → IDLE at M+1, grant low at M+1. The earliest next grant is M+2, so there is at least one IDLE (NOP) cycle between grants.
- Simultaneous requests in IDLE: highest priority wins. Losers keep their request asserted and are served later.
- A ref_req arriving during WRITE/READ waits; it is granted after that operation ends, ahead of any pending wr_req/rd_req.
- Reset mid-operation: immediate return to INIT with NOP pins. The in-flight sub-module is aborted because its grant drops.

## Structure
- Shared package sdram_pkg holds:
  - the state enum (INIT, IDLE, AREF, WRITE, READ)
  - command constants CMD_NOP=4'b0111, CMD_PRECHARGE=4'b0010, CMD_AUTOREFRESH=4'b0001
  - width parameters.
- One sub-module is natural: sdram_cmd_reg, the registered pin stage (cmd/ba/addr/dq/oe with reset-to-NOP). The FSM and mux stay in sdram_arbit.

## Test plan
- Reset then init_cmd=4'b0010, init_addr=12'h400 for 3 cycles → pins show 0010/400 one cycle later. After init_end_flag=1, next state is IDLE and pins show 0111.
- After init, pulse ref_req and wr_req in the same cycle → ref_en=1 next cycle and wr_en=0. Then ref_end_flag → one IDLE cycle → wr_en=1.
- WRITE granted, wr_dq=16'hA5A5, wr_dq_oe=1 → sdram_dq_out=A5A5 and sdram_dq_oe=1 one cycle later. In READ, sdram_dq_oe stays 0.
- ref_req rises mid-READ, with wr_req also pending → READ completes on rd_end_flag; AREF is granted before WRITE.
- Stray wr_end_flag during AREF → no state change; ref_en stays 1 until ref_end_flag.
- Assert sys_rst during WRITE → all grants 0 and pins NOP in the same cycle. After release, state is INIT until init_end_flag.
